control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the bus-based datapath. It generates, cycle by cycle, the register-select, bus-drive and ALU-operation strobes that the `bus` datapath consumes: fetch (T0–T2), then the execute steps for R-format ALU instructions and, optionally, mul/div. It decodes the instruction from the datapath's IR output and handshakes with memory through `read`/`mem_rdy`.

## Interface
- No parameters.
- `clock` in 1: rising-edge clock shared with the datapath.
- `clear` in 1: synchronous, active-low reset.
- `IR` in 32: instruction register contents; fields opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
- `mem_rdy` in 1: memory read data valid on `Mdatain` this cycle.
- `Rin` out 16: one-hot R0–R15 load enables.
- `Rout` out 16: one-hot R0–R15 bus drives.
- `PCout, ZLOout, ZHIout, MDRout` out 1 each: bus drives.
- `MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin` out 1 each: load enables.
- `IncPC, read` out 1 each: PC increment select, memory read request.
- `operation` out 5: ALU operation code.
- `run` out 1: high while executing, low in RST and HALT.

## Operation
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALT. All outputs are Moore, decoded from the state register and IR. Every output not listed for a state is 0.
- RST: all outputs 0, `run`=0. The next state is T0.
- T0: `PCout`, `MARin`, `IncPC`, `Zlowin`.
- T1: `ZLOout` and `read` are held.
  - `PCin` and `MDRin` are asserted only in the cycle where `mem_rdy`=1.
  - The state stays in T1 while `mem_rdy`=0, then goes to T2.
- T2: `MDRout`, `IRin`. IR is valid from T3 onward.
- T3 decodes the opcode:
  - R-format 00000–01011 and mul 01111/div 10000: assert `Rout[Rb]`, `Yin`; go to T4.
  - halt 11011: no strobes; go to HALT.
  - All other opcodes (including nop 11010): no strobes; go to T0.
- T4: `Rout[Rc]`, `Zlowin`, `operation`=opcode.
  - For mul/div, also assert `Zhighin`.
  - Outside T4, `operation`=5'b00000.
- T5:
  - R-format: `ZLOout`, `Rin[Ra]`; then go to T0.
  - mul/div: `ZLOout`, `LOin`; then go to T6.
- T6: `ZHIout`, `HIin`; then go to T0.
- HALT: all outputs 0, `run`=0. Only `clear` exits HALT.
- Register selects are 4-bit fields decoded to one-hot. Ra/Rb/Rc equal to each other is legal and decodes independently.
- `clear`=0 sampled at any edge, in any state (including mid-T1 wait), forces RST on that edge. Pending strobes drop the same edge.

## Timing
- Reset values: every output 0, `run`=0. RST lasts ≥1 cycle; the first T0 follows the first edge with `clear`=1.
- Strobes are stable for the whole state cycle. Datapath loads occur on the rising edge that ends the state.
- Cycles per instruction (zero-wait memory):
  - R-format: 6.
  - mul/div: 7.
  - nop/undefined: 4.
  - Each `mem_rdy`=0 cycle in T1 adds one cycle.
- `run` is registered with the state: it is 1 from T0 onward and falls in the cycle HALT is entered.

## Configuration
- `CTRL_MULDIV_EN` defined: opcodes 01111/10000 take the T3–T6 path. `Zhighin` is asserted in T4; `LOin`/`HIin` are written in T5/T6.
- Not defined: 01111/10000 decode as nop (T3→T0, no strobes).
  - The T6 state is absent.
  - `Zhighin`, `ZHIout`, `HIin`, `LOin` are tied 0.

## Test plan
- Reset, then `mem_rdy`=1, IR=32'h389A8000 (shr, Ra=R1, Rb=R3, Rc=R5):
  - T3 `Rout`=16'h0008 with `Yin`.
  - T4 `Rout`=16'h0020, `operation`=5'b00111, `Zlowin`.
  - T5 `Rin`=16'h0002 with `ZLOout`.
  - Back in T0 at cycle 7 after reset release.
- `mem_rdy` low for 3 cycles in T1:
  - `read`=1 for 4 cycles.
  - `PCin`/`MDRin` pulse once, in the 4th cycle.
  - T2 follows.
- IR=32'hD8000000 (halt): `run` falls after T3 and all outputs stay 0 for 20 cycles. Then `clear`=0 for one edge, and T0 strobes appear after release.
- IR opcode 01111 (mul, Rb=R2, Rc=R4):
  - With `CTRL_MULDIV_EN`: T4 `Zlowin`=`Zhighin`=1; T5 `LOin`; T6 `HIin`; 7 cycles total.
  - Without it: 4-cycle nop with no `Yin`.
- `clear`=0 asserted during T4: the next cycle has all outputs 0 and `run`=0; after release the sequence restarts at T0.
- IR opcode 11100 (undefined): T3 asserts nothing, the next state is T0, and `Rin` never nonzero.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the bus datapath: fetch T0-T2, then R-format execute T3-T5.
// Optional mul/div execute path (T4-T6 with HI/LO writes) is enabled by defining CTRL_MULDIV_EN.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_rdy,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCout,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        read,
  output logic [4:0]  operation,
  output logic        run
);

`ifdef CTRL_MULDIV_EN
  typedef enum logic [3:0] {
    StRst  = 4'd0,
    StT0   = 4'd1,
    StT1   = 4'd2,
    StT2   = 4'd3,
    StT3   = 4'd4,
    StT4   = 4'd5,
    StT5   = 4'd6,
    StT6   = 4'd7,
    StHalt = 4'd8
  } state_e;
`else
  typedef enum logic [3:0] {
    StRst  = 4'd0,
    StT0   = 4'd1,
    StT1   = 4'd2,
    StT2   = 4'd3,
    StT3   = 4'd4,
    StT4   = 4'd5,
    StT5   = 4'd6,
    StHalt = 4'd8
  } state_e;
`endif

  localparam logic [4:0] OpRfmtMax = 5'b01011;
  localparam logic [4:0] OpMul     = 5'b01111;
  localparam logic [4:0] OpDiv     = 5'b10000;
  localparam logic [4:0] OpHalt    = 5'b11011;

  state_e state_q, state_d;

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic [15:0] ra_oh, rb_oh, rc_oh;
  logic        is_rfmt, is_muldiv, is_halt, exec_op;
  logic        unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign ra_oh = 16'h0001 << ra;
  assign rb_oh = 16'h0001 << rb;
  assign rc_oh = 16'h0001 << rc;

  assign is_rfmt = (opcode <= OpRfmtMax);
`ifdef CTRL_MULDIV_EN
  assign is_muldiv = (opcode == OpMul) || (opcode == OpDiv);
`else
  assign is_muldiv = 1'b0;
`endif
  assign is_halt = (opcode == OpHalt);
  assign exec_op = is_rfmt || is_muldiv;

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst: state_d = StT0;
      StT0:  state_d = StT1;
      StT1:  state_d = mem_rdy ? StT2 : StT1;
      StT2:  state_d = StT3;
      StT3: begin
        if (exec_op) begin
          state_d = StT4;
        end else if (is_halt) begin
          state_d = StHalt;
        end else begin
          state_d = StT0;
        end
      end
      StT4:  state_d = StT5;
`ifdef CTRL_MULDIV_EN
      StT5:  state_d = is_muldiv ? StT6 : StT0;
      StT6:  state_d = StT0;
`else
      StT5:  state_d = StT0;
`endif
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  // Moore strobes; only the T1 memory handshake looks at an input directly.
  always_comb begin
    Rin       = 16'h0000;
    Rout      = 16'h0000;
    PCout     = 1'b0;
    ZLOout    = 1'b0;
    ZHIout    = 1'b0;
    MDRout    = 1'b0;
    MARin     = 1'b0;
    PCin      = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zlowin    = 1'b0;
    Zhighin   = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    IncPC     = 1'b0;
    read      = 1'b0;
    operation = 5'b00000;
    unique case (state_q)
      StT0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      StT1: begin
        ZLOout = 1'b1;
        read   = 1'b1;
        PCin   = mem_rdy;
        MDRin  = mem_rdy;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        if (exec_op) begin
          Rout = rb_oh;
          Yin  = 1'b1;
        end
      end
      StT4: begin
        Rout      = rc_oh;
        Zlowin    = 1'b1;
        operation = opcode;
`ifdef CTRL_MULDIV_EN
        Zhighin   = is_muldiv;
`endif
      end
      StT5: begin
        ZLOout = 1'b1;
        if (is_muldiv) begin
`ifdef CTRL_MULDIV_EN
          LOin = 1'b1;
`endif
        end else begin
          Rin = ra_oh;
        end
      end
`ifdef CTRL_MULDIV_EN
      StT6: begin
        ZHIout = 1'b1;
        HIin   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign run = (state_q != StRst) && (state_q != StHalt);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level expected-strobe queue checked every cycle,
// plus directed literal checks. Honours CTRL_MULDIV_EN the same way as the design.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] IR = 32'h0;
  logic        mem_rdy = 1'b1;
  logic [15:0] Rin, Rout;
  logic        PCout, ZLOout, ZHIout, MDRout, MARin, PCin, MDRin, IRin, Yin;
  logic        Zlowin, Zhighin, HIin, LOin, IncPC, read, run;
  logic [4:0]  operation;

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .mem_rdy(mem_rdy),
    .Rin(Rin), .Rout(Rout), .PCout(PCout), .ZLOout(ZLOout), .ZHIout(ZHIout),
    .MDRout(MDRout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .read(read), .operation(operation), .run(run)
  );

  always #5 clock = ~clock;

`ifdef CTRL_MULDIV_EN
  localparam bit MdEn = 1'b1;
`else
  localparam bit MdEn = 1'b0;
`endif

  // Output vector layout, LSB first: run, operation[5:1], read, IncPC, LOin, HIin, Zhighin,
  // Zlowin, Yin, IRin, MDRin, PCin, MARin, MDRout, ZHIout, ZLOout, PCout, Rout[36:21], Rin[52:37]
  logic [52:0] dutv;
  assign dutv = {Rin, Rout, PCout, ZLOout, ZHIout, MDRout, MARin, PCin, MDRin, IRin, Yin,
                 Zlowin, Zhighin, HIin, LOin, IncPC, read, operation, run};

  localparam logic [52:0] M_RUN     = 53'h1;
  localparam logic [52:0] M_READ    = 53'h1 << 6;
  localparam logic [52:0] M_INCPC   = 53'h1 << 7;
  localparam logic [52:0] M_LOIN    = 53'h1 << 8;
  localparam logic [52:0] M_HIIN    = 53'h1 << 9;
  localparam logic [52:0] M_ZHIGHIN = 53'h1 << 10;
  localparam logic [52:0] M_ZLOWIN  = 53'h1 << 11;
  localparam logic [52:0] M_YIN     = 53'h1 << 12;
  localparam logic [52:0] M_IRIN    = 53'h1 << 13;
  localparam logic [52:0] M_MDRIN   = 53'h1 << 14;
  localparam logic [52:0] M_PCIN    = 53'h1 << 15;
  localparam logic [52:0] M_MARIN   = 53'h1 << 16;
  localparam logic [52:0] M_MDROUT  = 53'h1 << 17;
  localparam logic [52:0] M_ZHIOUT  = 53'h1 << 18;
  localparam logic [52:0] M_ZLOOUT  = 53'h1 << 19;
  localparam logic [52:0] M_PCOUT   = 53'h1 << 20;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [52:0] rout_m(input logic [3:0] r);
    logic [15:0] oh;
    oh = 16'h0001 << r;
    return {16'h0000, oh, 21'h0};
  endfunction

  function automatic logic [52:0] rin_m(input logic [3:0] r);
    logic [15:0] oh;
    oh = 16'h0001 << r;
    return {oh, 37'h0};
  endfunction

  // Model: one expected strobe set per cycle of the current instruction.
  typedef struct packed {
    logic [52:0] v;
    bit          wait_mem;
    bit          to_halt;
  } rec_t;

  localparam int MReset = 0;
  localparam int MRun   = 1;
  localparam int MHalt  = 2;

  rec_t q[$];
  int   mode = MReset;
  bit   started = 1'b0;

  task automatic push(input logic [52:0] v, input bit w, input bit h);
    rec_t r;
    r.v = v | M_RUN;
    r.wait_mem = w;
    r.to_halt = h;
    q.push_back(r);
  endtask

  task automatic build();
    logic [4:0] op;
    bit rf, md, ex;
    op = IR[31:27];
    rf = (op <= 5'd11);
    md = MdEn && (op == 5'd15 || op == 5'd16);
    ex = rf || md;
    push(M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, 1'b0, 1'b0);
    push(M_ZLOOUT | M_READ, 1'b1, 1'b0);
    push(M_MDROUT | M_IRIN, 1'b0, 1'b0);
    push(ex ? (rout_m(IR[22:19]) | M_YIN) : 53'h0, 1'b0, op == 5'd27);
    if (ex) begin
      push(rout_m(IR[18:15]) | M_ZLOWIN | (md ? M_ZHIGHIN : 53'h0) | {47'h0, op, 1'b0},
           1'b0, 1'b0);
      push(M_ZLOOUT | (md ? M_LOIN : rin_m(IR[26:23])), 1'b0, 1'b0);
      if (md) push(M_ZHIOUT | M_HIIN, 1'b0, 1'b0);
    end
  endtask

  always @(posedge clock) begin
    started = 1'b1;
    if (!clear) begin
      mode = MReset;
      q.delete();
    end else if (mode == MReset) begin
      mode = MRun;
      build();
    end else if (mode == MRun && q.size() > 0) begin
      if (!(q[0].wait_mem && !mem_rdy)) begin
        bit h;
        h = q[0].to_halt;
        void'(q.pop_front());
        if (h) mode = MHalt;
        else if (q.size() == 0) build();
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      logic [52:0] e;
      e = 53'h0;
      if (mode == MRun && q.size() > 0) begin
        e = q[0].v;
        if (q[0].wait_mem && mem_rdy) e = e | M_PCIN | M_MDRIN;
      end
      chk("cycle_outputs", {11'h0, dutv}, {11'h0, e});
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench 1 time unit into the first T0 cycle.
  task automatic restart(input logic [31:0] ir);
    cycle();
    clear = 1'b0;
    IR = ir;
    cycle();
    #2;
    chk("reset_outputs", {11'h0, dutv}, 64'h0);
    clear = 1'b1;
    cycle();
  endtask

  // From T0, run to the next T0 and summarise what the instruction asserted.
  task automatic run_instr(output int n, output bit yin_s, output bit zhi_s, output bit lo_s,
                           output bit hi_s, output logic [15:0] rin_or);
    n = 1;
    yin_s = 1'b0; zhi_s = 1'b0; lo_s = 1'b0; hi_s = 1'b0; rin_or = 16'h0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      #2;
      if (PCout && MARin) break;
      n++;
      yin_s = yin_s | Yin;
      zhi_s = zhi_s | Zhighin;
      lo_s = lo_s | LOin;
      hi_s = hi_s | HIin;
      rin_or = rin_or | Rin;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  initial begin
    int n;
    bit ys, zs, ls, hs;
    logic [15:0] ro;
    logic [31:0] ir_mul, ir_und, ir_nop;
    ir_mul = {5'b01111, 4'd6, 4'd2, 4'd4, 15'd0};
    ir_und = {5'b11100, 4'd1, 4'd2, 4'd3, 15'd0};
    ir_nop = {5'b11010, 4'd7, 4'd8, 4'd9, 15'd0};

    // shr R1, R3, R5
    restart(32'h389A8000);
    #2;
    chk("t0_strobes", {11'h0, dutv}, {11'h0, M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN});
    cycle(); cycle(); cycle(); #2;
    chk("t3_rout", {48'h0, Rout}, 64'h0008);
    chk("t3_yin", {63'h0, Yin}, 64'h1);
    cycle(); #2;
    chk("t4_rout", {48'h0, Rout}, 64'h0020);
    chk("t4_op", {59'h0, operation}, 64'h07);
    chk("t4_zlowin", {63'h0, Zlowin}, 64'h1);
    cycle(); #2;
    chk("t5_rin", {48'h0, Rin}, 64'h0002);
    chk("t5_zloout", {63'h0, ZLOout}, 64'h1);
    cycle(); #2;
    chk("cycle7_t0", {63'h0, PCout & MARin}, 64'h1);

    // three wait cycles in T1
    mem_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      mem_rdy = (i == 3);
      #2;
      chk("t1_read", {63'h0, read}, 64'h1);
      chk("t1_pcin", {62'h0, PCin, MDRin}, (i == 3) ? 64'h3 : 64'h0);
    end
    cycle(); #2;
    chk("t2_after_wait", {63'h0, IRin & MDRout}, 64'h1);
    cycle(); cycle(); cycle(); cycle(); #2;
    chk("t0_after_wait", {63'h0, PCout}, 64'h1);

    // halt
    restart(32'hD8000000);
    cycle(); cycle(); cycle(); #2;
    chk("halt_t3_run", {11'h0, dutv}, {11'h0, M_RUN});
    cycle(); #2;
    chk("halt_run_low", {63'h0, run}, 64'h0);
    for (int i = 0; i < 20; i++) begin
      cycle(); #2;
      chk("halt_idle", {11'h0, dutv}, 64'h0);
    end
    clear = 1'b0;
    cycle(); #2;
    chk("halt_clear", {11'h0, dutv}, 64'h0);
    clear = 1'b1;
    cycle(); #2;
    chk("halt_exit_t0", {11'h0, dutv}, {11'h0, M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN});

    // mul
    restart(ir_mul);
    run_instr(n, ys, zs, ls, hs, ro);
    chk("mul_cycles", 64'(n), MdEn ? 64'd7 : 64'd4);
    chk("mul_yin", {63'h0, ys}, {63'h0, MdEn});
    chk("mul_zhighin", {63'h0, zs}, {63'h0, MdEn});
    chk("mul_loin", {63'h0, ls}, {63'h0, MdEn});
    chk("mul_hiin", {63'h0, hs}, {63'h0, MdEn});
    chk("mul_rin", {48'h0, ro}, 64'h0);

    // clear during T4
    restart(32'h389A8000);
    cycle(); cycle(); cycle(); cycle(); #2;
    chk("t4_before_clear", {63'h0, Zlowin}, 64'h1);
    clear = 1'b0;
    cycle(); #2;
    chk("clear_in_t4", {11'h0, dutv}, 64'h0);
    clear = 1'b1;
    cycle(); #2;
    chk("restart_t0", {11'h0, dutv}, {11'h0, M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN});

    // undefined opcode, twice in a row, then nop
    restart(ir_und);
    for (int k = 0; k < 2; k++) begin
      run_instr(n, ys, zs, ls, hs, ro);
      chk("undef_cycles", 64'(n), 64'd4);
      chk("undef_rin", {48'h0, ro}, 64'h0);
      chk("undef_yin", {63'h0, ys}, 64'h0);
    end
    restart(ir_nop);
    run_instr(n, ys, zs, ls, hs, ro);
    chk("nop_cycles", 64'(n), 64'd4);

    cycle(); cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
